// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial blocks. Holds the
//               serializer state encoding and a clog2 helper that sizes
//               bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

  // Serializer state: IDLE waits for a word, SHIFT drains one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2. The result is at least 1, so a counter built from it
  // always has a legal width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer_if.sv
// ============================================================================
// Module      : piso_serializer_if
// Description : Load and serial handshake bundle for piso_serializer.
//               master : word producer and bit consumer (drives din,
//                        load_valid and sout_ready)
//               slave  : the serializer itself
//   din        N  parallel word
//   load_valid 1  din is valid
//   load_ready 1  serializer accepts din this cycle
//   sout       1  current serial bit
//   sout_valid 1  sout carries a valid bit
//   sout_ready 1  consumer takes sout this cycle
//   busy       1  a word is in progress
//   done       1  one-cycle pulse after the last bit of a word is taken
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
  parameter int N = 4
);

  logic [N-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         busy;
  logic         done;

  modport master (
    output din,
    output load_valid,
    output sout_ready,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    input  sout_ready,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );

endinterface

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module      : piso_shift_reg
// Description : N-bit shift register with a serial output tap. The word
//               moves toward the tap end and zeros are filled in behind it.
//   clk     1  rising-edge clock
//   reset_n 1  asynchronous active-low clear
//   load    1  capture din (highest priority)
//   clear   1  synchronous clear to zero
//   shift   1  move one bit toward the tap
//   din     N  parallel word
//   tap     1  serial output bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         load,
  input  wire logic         clear,
  input  wire logic         shift,
  input  wire logic [N-1:0] din,
  output logic              tap
);

  logic [N-1:0] shreg;
  logic [N-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg[N-2:0], 1'b0};
      assign tap     = shreg[N-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, shreg[N-1:1]};
      assign tap     = shreg[0];
    end
  endgenerate

  // A back-to-back load coincides with the last shift; the load wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (clear) begin
      shreg <= '0;
    end else if (shift) begin
      shreg <= shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out converter. Accepts an N-bit word on
//               a valid/ready load handshake and emits one bit per serial
//               beat. Pulses done after the last bit of each word; a new
//               word can be accepted on the same edge that takes the last
//               bit, so back-to-back words stream without a bubble.
//   clk     1  rising-edge clock
//   reset_n 1  asynchronous active-low reset
//   bus     -  piso_serializer_if.slave (din, load/serial handshakes,
//              busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer
  import serial_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  piso_serializer_if.slave bus
);

  localparam int CW = clog2(N + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          done_r;
  logic          done_next;

  logic sr_load;
  logic sr_clear;
  logic sr_shift;
  logic tap;

  logic in_shift;
  logic beat;
  logic last_bit;
  logic load_ready;
  logic load_fire;

  assign in_shift = (state == SHIFT);
  assign beat     = in_shift && bus.sout_ready;
  assign last_bit = (cnt == CW'(1));

  // Ready while idle, or when the final bit is being taken this cycle so
  // the next word slots in without an idle beat.
  assign load_ready = (state == IDLE) || (in_shift && last_bit && bus.sout_ready);
  assign load_fire  = bus.load_valid && load_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      done_r <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    sr_load    = 1'b0;
    sr_clear   = 1'b0;
    sr_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) begin
          sr_load    = 1'b1;
          cnt_next   = CW'(N);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (!last_bit) begin
            sr_shift = 1'b1;
            cnt_next = cnt - CW'(1);
          end else begin
            done_next = 1'b1;
            if (load_fire) begin
              sr_load  = 1'b1;
              cnt_next = CW'(N);
            end else begin
              sr_clear   = 1'b1;
              cnt_next   = '0;
              state_next = IDLE;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  piso_shift_reg #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sr_load),
    .clear   (sr_clear),
    .shift   (sr_shift),
    .din     (bus.din),
    .tap     (tap)
  );

  assign bus.load_ready = load_ready;
  assign bus.sout       = tap;
  assign bus.sout_valid = in_shift;
  assign bus.busy       = in_shift;
  assign bus.done       = done_r;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench. Drives an MSB-first and an LSB-first
//               serializer with identical stimulus and compares every
//               output, every cycle, against a word/bit-position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  localparam int N = 4;

  logic clk;
  logic reset_n;

  piso_serializer_if #(.N(N)) if_m ();
  piso_serializer_if #(.N(N)) if_l ();

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_m.slave)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the word being emitted and how many bits remain.
  logic [N-1:0] m_word = '0;
  int           m_rem  = 0;
  logic         m_done = 1'b0;
  bit           load_fired = 1'b0;

  // Bits actually taken by the consumer, newest in bit 0.
  logic [31:0] got_m = '0;
  logic [31:0] got_l = '0;
  int          n_beats = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic [N-1:0] d, input logic lv, input logic sr);
    if_m.din = d;  if_m.load_valid = lv;  if_m.sout_ready = sr;
    if_l.din = d;  if_l.load_valid = lv;  if_l.sout_ready = sr;
  endtask

  // k-th emitted bit of a word: MSB-first walks down from N-1, LSB-first up from 0.
  function automatic logic exp_sout(input bit msb);
    int k;
    if (m_rem == 0) return 1'b0;
    k = N - m_rem;
    return msb ? m_word[N-1-k] : m_word[k];
  endfunction

  function automatic logic exp_load_ready();
    return (m_rem == 0) || (m_rem == 1 && if_m.sout_ready);
  endfunction

  task automatic check_outputs();
    logic busy_e;
    busy_e = (m_rem > 0);
    chk("msb_sout",       32'(if_m.sout),       32'(exp_sout(1'b1)));
    chk("lsb_sout",       32'(if_l.sout),       32'(exp_sout(1'b0)));
    chk("msb_sout_valid", 32'(if_m.sout_valid), 32'(busy_e));
    chk("lsb_sout_valid", 32'(if_l.sout_valid), 32'(busy_e));
    chk("msb_busy",       32'(if_m.busy),       32'(busy_e));
    chk("lsb_busy",       32'(if_l.busy),       32'(busy_e));
    chk("msb_load_ready", 32'(if_m.load_ready), 32'(exp_load_ready()));
    chk("lsb_load_ready", 32'(if_l.load_ready), 32'(exp_load_ready()));
    chk("msb_done",       32'(if_m.done),       32'(m_done));
    chk("lsb_done",       32'(if_l.done),       32'(m_done));
    if (reset_n && busy_e && if_m.sout_ready) begin
      got_m = {got_m[30:0], if_m.sout};
      got_l = {got_l[30:0], if_l.sout};
      n_beats++;
    end
  endtask

  task automatic model_update();
    bit beat;
    bit ld;
    beat = (m_rem > 0) && if_m.sout_ready;
    ld   = if_m.load_valid && exp_load_ready();
    m_done = beat && (m_rem == 1);
    if (beat) m_rem--;
    if (ld) begin
      m_word = if_m.din;
      m_rem  = N;
    end
    load_fired = ld;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    load_fired = 1'b0;
    if (reset_n) model_update();
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    #2;
    reset_n = 1'b0;
    m_rem  = 0;
    m_word = '0;
    m_done = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    reset_n = 1'b1;
  endtask

  task automatic clear_log();
    got_m = '0;
    got_l = '0;
    n_beats = 0;
  endtask

  // Present a word and hold it until the load handshake fires.
  task automatic send_word(input logic [N-1:0] w, input logic sr);
    bit ok;
    ok = 1'b0;
    set_in(w, 1'b1, sr);
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      ok = load_fired;
    end
    if (!ok) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_steps(input int n);
    set_in('0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    set_in('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    idle_steps(2);

    // Single word 1011.
    clear_log();
    send_word(4'b1011, 1'b1);
    idle_steps(6);
    chk("single_beats", 32'(n_beats), 32'd4);
    chk("single_msb_bits", got_m & 32'hF, 32'b1011);
    chk("single_lsb_bits", got_l & 32'hF, 32'b1101);

    // Back-to-back 1011 then 0110 with load_valid held.
    clear_log();
    send_word(4'b1011, 1'b1);
    send_word(4'b0110, 1'b1);
    idle_steps(6);
    chk("b2b_beats", 32'(n_beats), 32'd8);
    chk("b2b_msb_bits", got_m & 32'hFF, 32'b10110110);
    chk("b2b_lsb_bits", got_l & 32'hFF, 32'b11010110);

    // Backpressure on 1001.
    clear_log();
    send_word(4'b1001, 1'b1);
    begin
      logic [6:0] pat;
      pat = 7'b1001101;
      for (int i = 6; i >= 0; i--) begin
        set_in('0, 1'b0, pat[i]);
        step();
      end
    end
    idle_steps(3);
    chk("bp_beats", 32'(n_beats), 32'd4);
    chk("bp_msb_bits", got_m & 32'hF, 32'b1001);
    chk("bp_lsb_bits", got_l & 32'hF, 32'b1001);

    // Reset after two bits of 1100, then a clean reload.
    send_word(4'b1100, 1'b1);
    set_in('0, 1'b0, 1'b1);
    step();
    step();
    apply_reset(2);
    idle_steps(2);
    clear_log();
    send_word(4'b1100, 1'b1);
    idle_steps(6);
    chk("rst_reload_beats", 32'(n_beats), 32'd4);
    chk("rst_reload_msb_bits", got_m & 32'hF, 32'b1100);
    chk("rst_reload_lsb_bits", got_l & 32'hF, 32'b0011);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      set_in(N'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 79) == 0) begin
        apply_reset(1);
      end else begin
        step();
      end
    end
    idle_steps(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
